// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: takes single/burst commands, buffers write data,
// runs classic or incrementing-burst cycles and aborts cycles that are never acknowledged.
module wb_burst_master #(
  parameter int DW        = 32,
  parameter int AW        = 26,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 255,
  localparam int LW       = $clog2(MAX_BURST) + 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  input  logic [DW-1:0]   wdata,
  output logic            rdata_valid,
  output logic [DW-1:0]   rdata,
  output logic            rdata_last,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            busy,
  output logic            timeout_err
);
  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // WFILL | collecting write words into the buffer
  // BUS   | Wishbone cycle in progress, watchdog running
  typedef enum logic [1:0] {S_IDLE, S_WFILL, S_BUS} state_t;

  localparam int PW  = $clog2(MAX_BURST);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0]  MAX_LEN = LW'(MAX_BURST);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);
  localparam logic [AW-1:0]  STEP    = AW'(DW / 8);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  state_t state_q, state_d;
  logic cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dat_o_q, dat_o_d, rdata_q, rdata_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [2:0] cti_q, cti_d;
  logic cmd_ready_q, cmd_ready_d, wdata_ready_q, wdata_ready_d;
  logic rdata_valid_q, rdata_valid_d, rdata_last_q, rdata_last_d;
  logic busy_q, busy_d, terr_q, terr_d;
  logic [LW-1:0] len_q, len_d, left_q, left_d, wcnt_q, wcnt_d, len_n;
  logic [PW-1:0] rptr_q, rptr_d, rptr_nx;
  logic [WDW-1:0] wd_q, wd_d;
  logic [DW-1:0] mem_q [MAX_BURST];
  logic mem_we;

  assign rptr_nx = rptr_q + PW'(1);

  always_comb begin
    state_d = state_q;  cyc_d = cyc_q;  stb_d = stb_q;  we_d = we_q;
    addr_d = addr_q;  dat_o_d = dat_o_q;  sel_d = sel_q;  cti_d = cti_q;
    rdata_d = rdata_q;  rdata_valid_d = 1'b0;  rdata_last_d = 1'b0;
    terr_d = terr_q;  len_d = len_q;  left_d = left_q;  wcnt_d = wcnt_q;
    rptr_d = rptr_q;  wd_d = wd_q;  mem_we = 1'b0;
    len_n = cmd_len;
    if (cmd_len == '0) len_n = LW'(1);
    else if (cmd_len > MAX_LEN) len_n = MAX_LEN;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          terr_d = 1'b0;  addr_d = cmd_addr;  sel_d = cmd_sel;
          len_d = len_n;  left_d = len_n;  wcnt_d = '0;  rptr_d = '0;  wd_d = WD_LOAD;
          if (cmd_we) begin
            state_d = S_WFILL;
          end else begin
            state_d = S_BUS;  cyc_d = 1'b1;  stb_d = 1'b1;  we_d = 1'b0;
            cti_d = (len_n == LW'(1)) ? CTI_CLASSIC : CTI_INCR;
          end
        end
      end
      S_WFILL: begin
        if (wdata_valid && wdata_ready_q) begin
          mem_we = 1'b1;
          wcnt_d = wcnt_q + LW'(1);
          if (wcnt_q + LW'(1) == len_q) begin
            // single-word writes bypass the buffer: word 0 is being stored on this edge
            state_d = S_BUS;  cyc_d = 1'b1;  stb_d = 1'b1;  we_d = 1'b1;
            cti_d = (len_q == LW'(1)) ? CTI_CLASSIC : CTI_INCR;
            dat_o_d = (len_q == LW'(1)) ? wdata : mem_q[0];
            rptr_d = '0;  wd_d = WD_LOAD;
          end
        end
      end
      S_BUS: begin
        if (wb_ack_i && stb_q) begin
          wd_d = WD_LOAD;
          if (!we_q) begin
            rdata_d = wb_dat_i;  rdata_valid_d = 1'b1;
          end
          if (left_q == LW'(1)) begin
            state_d = S_IDLE;  cyc_d = 1'b0;  stb_d = 1'b0;  we_d = 1'b0;  cti_d = '0;
            rdata_last_d = !we_q;  wcnt_d = '0;  rptr_d = '0;
          end else begin
            left_d = left_q - LW'(1);  addr_d = addr_q + STEP;
            rptr_d = rptr_nx;  dat_o_d = mem_q[rptr_nx];
            cti_d = (left_q == LW'(2)) ? CTI_EOB : CTI_INCR;
          end
        end else if (wd_q == '0) begin
          state_d = S_IDLE;  cyc_d = 1'b0;  stb_d = 1'b0;  we_d = 1'b0;  cti_d = '0;
          terr_d = 1'b1;  wcnt_d = '0;  rptr_d = '0;
        end else begin
          wd_d = wd_q - WDW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d   = (state_d == S_IDLE);
    wdata_ready_d = (state_d == S_WFILL);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;  cyc_q <= 1'b0;  stb_q <= 1'b0;  we_q <= 1'b0;
      addr_q <= '0;  dat_o_q <= '0;  sel_q <= '0;  cti_q <= '0;
      rdata_q <= '0;  rdata_valid_q <= 1'b0;  rdata_last_q <= 1'b0;
      cmd_ready_q <= 1'b1;  wdata_ready_q <= 1'b0;  busy_q <= 1'b0;  terr_q <= 1'b0;
      len_q <= '0;  left_q <= '0;  wcnt_q <= '0;  rptr_q <= '0;  wd_q <= '0;
    end else begin
      state_q <= state_d;  cyc_q <= cyc_d;  stb_q <= stb_d;  we_q <= we_d;
      addr_q <= addr_d;  dat_o_q <= dat_o_d;  sel_q <= sel_d;  cti_q <= cti_d;
      rdata_q <= rdata_d;  rdata_valid_q <= rdata_valid_d;  rdata_last_q <= rdata_last_d;
      cmd_ready_q <= cmd_ready_d;  wdata_ready_q <= wdata_ready_d;
      busy_q <= busy_d;  terr_q <= terr_d;
      len_q <= len_d;  left_q <= left_d;  wcnt_q <= wcnt_d;  rptr_q <= rptr_d;  wd_q <= wd_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem_q[wcnt_q[PW-1:0]] <= wdata;
  end

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rdata_last_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = addr_q;
  assign wb_dat_o    = dat_o_q;
  assign wb_sel_o    = sel_q;
  assign wb_cti_o    = cti_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a vector table for the write burst and single read,
// plus hand-written sequences for bursts, watchdog abort, mid-cycle reset and length clamping.
module tb_wb_burst_master;
  localparam int DW = 32, AW = 26, MB = 8, TO = 16, LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cmd_valid, cmd_ready, cmd_we, wdata_valid, wdata_ready;
  logic [AW-1:0] cmd_addr, wb_addr_o;
  logic [LW-1:0] cmd_len;
  logic [3:0] cmd_sel, wb_sel_o;
  logic [DW-1:0] wdata, rdata, wb_dat_o, wb_dat_i, dat_drv;
  logic rdata_valid, rdata_last, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, busy, timeout_err;
  logic [2:0] wb_cti_o;
  logic use_model;

  // slave read data: either table-driven or derived from the current address
  assign wb_dat_i = use_model ? (32'hC0DE_0000 | 32'(wb_addr_o)) : dat_drv;

  wb_burst_master #(.DW(DW), .AW(AW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {cyc, stb, we, cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, timeout_err}
  function automatic logic [8:0] ctrl();
    return {wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, wdata_ready, rdata_valid, rdata_last,
            busy, timeout_err};
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
    wdata_valid = 0; wdata = '0; wb_ack_i = 0; dat_drv = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, 64'(ctrl()), 64'(9'b000_10_00_0_0));
    chk({tag, "_addr_sel_cti"}, 64'({wb_addr_o, wb_sel_o, wb_cti_o}), 64'd0);
    chk({tag, "_dat_o"}, 64'(wb_dat_o), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_len = l; cmd_sel = 4'hF;
    step();
    cmd_valid = 0;
  endtask

  typedef struct {
    logic cv; logic cwe; logic [AW-1:0] caddr; logic [LW-1:0] clen;
    logic wv; logic [DW-1:0] wd; logic ack; logic [DW-1:0] di;
    logic [8:0] ectl; logic [AW-1:0] eaddr; logic [DW-1:0] edat; logic [2:0] ecti;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cnt, rv_cnt, rl_cnt;
    logic saw_last;

    // write burst across the 2^26 address wrap, with a fill gap and one wait state
    tbl[0]  = '{1, 1, 26'h3FFFFF8, 4, 0, 0,            0, 0, 9'b000_01_00_1_0, 0,          0,            0, 0};
    tbl[1]  = '{0, 0, 0,           0, 1, 32'hAAAA_00A0, 0, 0, 9'b000_01_00_1_0, 0,          0,            0, 0};
    tbl[2]  = '{0, 0, 0,           0, 0, 0,            0, 0, 9'b000_01_00_1_0, 0,          0,            0, 0};
    tbl[3]  = '{0, 0, 0,           0, 1, 32'hAAAA_00A1, 0, 0, 9'b000_01_00_1_0, 0,          0,            0, 0};
    tbl[4]  = '{0, 0, 0,           0, 1, 32'hAAAA_00A2, 0, 0, 9'b000_01_00_1_0, 0,          0,            0, 0};
    tbl[5]  = '{0, 0, 0,           0, 1, 32'hAAAA_00A3, 0, 0, 9'b111_00_00_1_0, 26'h3FFFFF8, 32'hAAAA_00A0, 3'b010, 0};
    tbl[6]  = '{0, 0, 0,           0, 0, 0,            0, 0, 9'b111_00_00_1_0, 26'h3FFFFF8, 32'hAAAA_00A0, 3'b010, 0};
    tbl[7]  = '{0, 0, 0,           0, 0, 0,            1, 0, 9'b111_00_00_1_0, 26'h3FFFFFC, 32'hAAAA_00A1, 3'b010, 0};
    tbl[8]  = '{0, 0, 0,           0, 0, 0,            1, 0, 9'b111_00_00_1_0, 26'h0000000, 32'hAAAA_00A2, 3'b010, 0};
    tbl[9]  = '{0, 0, 0,           0, 0, 0,            1, 0, 9'b111_00_00_1_0, 26'h0000004, 32'hAAAA_00A3, 3'b111, 0};
    tbl[10] = '{0, 0, 0,           0, 0, 0,            1, 0, 9'b000_10_00_0_0, 0,          0,            0, 0};
    // single classic read at 0x100, ack after two wait cycles; stray ack when idle ignored
    tbl[11] = '{1, 0, 26'h100,     1, 0, 0,            0, 0, 9'b110_00_00_1_0, 26'h100,    0,            3'b000, 0};
    tbl[12] = '{0, 0, 0,           0, 0, 0,            0, 0, 9'b110_00_00_1_0, 26'h100,    0,            3'b000, 0};
    tbl[13] = '{0, 0, 0,           0, 0, 0,            0, 0, 9'b110_00_00_1_0, 26'h100,    0,            3'b000, 0};
    tbl[14] = '{0, 0, 0,           0, 0, 0,            1, 32'hDEADBEEF, 9'b000_10_11_0_0, 0,   0,            0, 32'hDEADBEEF};
    tbl[15] = '{0, 0, 0,           0, 0, 0,            1, 32'h1234_5678, 9'b000_10_00_0_0, 0,  0,            0, 0};

    use_model = 0;
    idle_inputs();
    rst = 1;
    step(); step();
    check_reset("reset");
    rst = 0;

    for (int i = 0; i < 16; i++) begin
      cmd_valid = tbl[i].cv; cmd_we = tbl[i].cwe; cmd_addr = tbl[i].caddr;
      cmd_len = tbl[i].clen; cmd_sel = 4'hF;
      wdata_valid = tbl[i].wv; wdata = tbl[i].wd; wb_ack_i = tbl[i].ack; dat_drv = tbl[i].di;
      step();
      chk($sformatf("vec%0d_ctl", i), 64'(ctrl()), 64'(tbl[i].ectl));
      if (tbl[i].ectl[8]) begin
        chk($sformatf("vec%0d_addr", i), 64'(wb_addr_o), 64'(tbl[i].eaddr));
        chk($sformatf("vec%0d_cti", i), 64'(wb_cti_o), 64'(tbl[i].ecti));
        chk($sformatf("vec%0d_sel", i), 64'(wb_sel_o), 64'h0F);
        if (tbl[i].ectl[6]) chk($sformatf("vec%0d_dat_o", i), 64'(wb_dat_o), 64'(tbl[i].edat));
      end
      if (tbl[i].ectl[3]) chk($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(tbl[i].erd));
    end
    idle_inputs();
    step();

    // 8-beat read with ack held high: back-to-back beats, EOB only on beat 8
    use_model = 1;
    wb_ack_i = 1;
    send_cmd(0, 26'h200, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rd8_stb_b%0d", k), 64'(wb_stb_o), 64'd1);
      chk($sformatf("rd8_cti_b%0d", k), 64'(wb_cti_o), (k == 7) ? 64'd7 : 64'd2);
      chk($sformatf("rd8_addr_b%0d", k), 64'(wb_addr_o), 64'(26'h200 + 4 * k));
      step();
      chk($sformatf("rd8_rv_b%0d", k), 64'(rdata_valid), 64'd1);
      chk($sformatf("rd8_rdata_b%0d", k), 64'(rdata), 64'(32'hC0DE_0200 + 4 * k));
      chk($sformatf("rd8_rlast_b%0d", k), 64'(rdata_last), (k == 7) ? 64'd1 : 64'd0);
    end
    chk("rd8_end_cyc", 64'(wb_cyc_o), 64'd0);
    wb_ack_i = 0;
    step();

    // watchdog: two beats acknowledged, then silence
    wb_ack_i = 1;
    send_cmd(0, 26'h300, 4);
    step();
    chk("to_beat1_rv", 64'(rdata_valid), 64'd1);
    step();
    wb_ack_i = 0;
    chk("to_beat2_rv", 64'({rdata_valid, rdata_last}), 64'b10);
    cnt = 0; rv_cnt = 0; rl_cnt = 0;
    while (wb_cyc_o && cnt < 40) begin
      cnt++;
      step();
      rv_cnt += int'(rdata_valid);
      rl_cnt += int'(rdata_last);
    end
    chk("to_cyc_cycles", 64'(cnt), 64'd16);
    chk("to_extra_rv_rlast", 64'(rv_cnt + rl_cnt), 64'd0);
    chk("to_ctl", 64'(ctrl()), 64'(9'b000_10_00_0_1));
    step();
    chk("to_err_sticky", 64'(timeout_err), 64'd1);
    send_cmd(0, 26'h0, 1);
    chk("to_err_cleared", 64'(timeout_err), 64'd0);
    wb_ack_i = 1;
    step();
    chk("to_next_done", 64'({rdata_valid, rdata_last, wb_cyc_o}), 64'b110);
    wb_ack_i = 0;
    step();

    // reset in the middle of a write fill, then a fresh write must use only new words
    send_cmd(1, 26'h500, 4);
    wdata_valid = 1; wdata = 32'hBBBB_00B0;
    step();
    wdata = 32'hBBBB_00B1;
    step();
    wdata_valid = 0;
    rst = 1;
    step();
    rst = 0;
    check_reset("rst_wfill");
    send_cmd(1, 26'h600, 2);
    wdata_valid = 1; wdata = 32'hCCCC_00C0;
    step();
    wdata = 32'hCCCC_00C1;
    step();
    wdata_valid = 0;
    chk("post_rst_cyc_we", 64'({wb_cyc_o, wb_we_o}), 64'b11);
    chk("post_rst_dat0", 64'(wb_dat_o), 64'hCCCC_00C0);
    wb_ack_i = 1;
    step();
    chk("post_rst_dat1", 64'(wb_dat_o), 64'hCCCC_00C1);
    chk("post_rst_addr1_cti", 64'({wb_addr_o, wb_cti_o}), 64'({26'h604, 3'b111}));
    step();
    wb_ack_i = 0;
    chk("post_rst_done", 64'(ctrl()), 64'(9'b000_10_00_0_0));

    // reset in the middle of a read burst
    wb_ack_i = 1;
    send_cmd(0, 26'h700, 4);
    step();
    rst = 1;
    step();
    rst = 0; wb_ack_i = 0;
    check_reset("rst_bus");

    // cmd_len 0 behaves as a single classic cycle
    send_cmd(0, 26'h40, 0);
    chk("len0_cti", 64'({wb_cyc_o, wb_cti_o}), 64'({1'b1, 3'b000}));
    wb_ack_i = 1;
    step();
    chk("len0_done", 64'({rdata_valid, rdata_last, wb_cyc_o}), 64'b110);
    wb_ack_i = 0;
    step();

    // cmd_len 15 clamps to MAX_BURST beats
    wb_ack_i = 1;
    send_cmd(0, 26'h800, 15);
    cnt = 0; rv_cnt = 0; saw_last = 0;
    while (!saw_last && cnt < 20) begin
      cnt++;
      step();
      rv_cnt += int'(rdata_valid);
      saw_last = rdata_last;
    end
    wb_ack_i = 0;
    chk("len15_saw_last", 64'(saw_last), 64'd1);
    chk("len15_beats", 64'(rv_cnt), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
